// File: rtl/bias_sram_if.sv
// Host-side bus of the bias SRAM reader: burst request, word write, and bias stream.
interface bias_sram_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W:0]   req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_base, req_len, wr_valid, wr_addr, wr_data, out_ready,
    input  req_ready, wr_ready, out_valid, out_data, out_last, done, err
  );

  modport slave (
    input  req_valid, req_base, req_len, wr_valid, wr_addr, wr_data, out_ready,
    output req_ready, wr_ready, out_valid, out_data, out_last, done, err
  );
endinterface

// File: rtl/bias_sram_reader.sv
// Sole driver of the bias SRAM macro: idle-time word writes, credit-paced burst reads
// through a one-cycle read pipeline into a 2-entry output FIFO.
module bias_sram_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 384
)(
  input  logic              clk,
  input  logic              rst,
  bias_sram_if.slave        bus,
  output logic              sram_cs,
  output logic              sram_web,
  output logic              sram_oe,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_LEN = (ADDR_W+1)'(1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              inflight, inflight_last;
  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              rptr, wptr;
  logic [1:0]        count;
  logic [ADDR_W-1:0] a_hold;
  logic [DATA_W-1:0] di_hold;
  logic              done_q, err_q, oe_q;

  logic              issue, pop, credit_ok, last_issue;
  logic              req_fire, req_bad, req_empty, accept_burst;
  logic              wr_fire, wr_ok, wr_issue;
  logic [ADDR_W+1:0] req_end;
  logic [2:0]        used;

  assign req_fire     = bus.req_valid & bus.req_ready;
  assign req_end      = {2'b00, bus.req_base} + {1'b0, bus.req_len};
  assign req_bad      = req_end > DEPTH_X;
  assign req_empty    = bus.req_len == '0;
  assign accept_burst = req_fire & ~req_bad & ~req_empty;
  assign wr_fire      = bus.wr_valid & bus.wr_ready;
  assign wr_ok        = {1'b0, bus.wr_addr} < DEPTH_A;
  assign wr_issue     = wr_fire & wr_ok;
  assign last_issue   = remaining == ONE_LEN;

  assign bus.out_valid = count != 2'd0;
  assign bus.out_data  = fifo_data[rptr];
  assign bus.out_last  = bus.out_valid & fifo_last[rptr];
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign sram_oe       = oe_q;
  assign pop           = bus.out_valid & bus.out_ready;

  // A head pop this cycle frees its slot in time for the word issued now, which is
  // what sustains one word per cycle through a 2-deep FIFO.
  assign used      = {1'b0, count} + {2'b00, inflight};
  assign credit_ok = used < (3'd2 + {2'b00, pop});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_burst) state_nx = READ;
      READ:    if (issue && last_issue) state_nx = DRAIN;
      DRAIN:   if (pop && fifo_last[rptr]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    issue         = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          bus.req_ready = 1'b1;
          bus.wr_ready  = ~bus.req_valid;
        end
        READ:    issue = credit_ok;
        default: ;
      endcase
    end
    sram_cs  = issue | wr_issue;
    sram_web = ~wr_issue;
    sram_a   = issue ? addr : (wr_issue ? bus.wr_addr : a_hold);
    sram_di  = wr_issue ? bus.wr_data : di_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last     <= '0;
      rptr          <= 1'b0;
      wptr          <= 1'b0;
      count         <= 2'd0;
      a_hold        <= '0;
      di_hold       <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      oe_q          <= 1'b0;
    end else begin
      oe_q <= 1'b1;
      if (sram_cs)  a_hold  <= sram_a;
      if (wr_issue) di_hold <= bus.wr_data;
      if (accept_burst) begin
        addr      <= bus.req_base;
        remaining <= bus.req_len;
      end else if (issue) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      inflight      <= issue;
      inflight_last <= issue & last_issue;
      // Macro output is valid the cycle after the issue edge.
      if (inflight) begin
        fifo_data[wptr] <= sram_do;
        fifo_last[wptr] <= inflight_last;
        wptr            <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({inflight, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
      done_q <= (req_fire & ~req_bad & req_empty) | (pop & fifo_last[rptr]);
      err_q  <= (req_fire & req_bad) | (wr_fire & ~wr_ok);
    end
  end
endmodule
